// File: rtl/booth_mul_param_if.sv
// Bus bundle between a CPU-side register block (master) and booth_mul_param (slave).
// The i_accEn member exists only when BOOTH_MUL_ACC_EN is defined.
interface booth_mul_param_if #(
  parameter int WIDTH = 16
);
  logic                 i_start;
  logic                 i_ack;
  logic                 i_signedMode;
  logic                 i_irqEnable;
  logic [WIDTH-1:0]     i_dataA;
  logic [WIDTH-1:0]     i_dataB;
`ifdef BOOTH_MUL_ACC_EN
  logic                 i_accEn;
`endif
  logic                 o_busy;
  logic                 o_irq;
  logic                 o_done;
  logic [2*WIDTH-1:0]   o_result;

`ifdef BOOTH_MUL_ACC_EN
  modport master (
    output i_start, i_ack, i_signedMode, i_irqEnable, i_dataA, i_dataB, i_accEn,
    input  o_busy, o_irq, o_done, o_result
  );
  modport slave (
    input  i_start, i_ack, i_signedMode, i_irqEnable, i_dataA, i_dataB, i_accEn,
    output o_busy, o_irq, o_done, o_result
  );
`else
  modport master (
    output i_start, i_ack, i_signedMode, i_irqEnable, i_dataA, i_dataB,
    input  o_busy, o_irq, o_done, o_result
  );
  modport slave (
    input  i_start, i_ack, i_signedMode, i_irqEnable, i_dataA, i_dataB,
    output o_busy, o_irq, o_done, o_result
  );
`endif
endinterface

// File: rtl/booth_mul_param.sv
// Sequential radix-4 Booth multiplier, WIDTH/2+1 steps per product, busy/irq/ack handshake.
// Optional accumulate mode (result += product) when BOOTH_MUL_ACC_EN is defined.
module booth_mul_param #(
  parameter int WIDTH = 16
) (
  input logic              i_clk,
  input logic              i_resetn,
  booth_mul_param_if.slave bus
);
  localparam int NSTEP = WIDTH / 2 + 1;
  localparam int EW    = WIDTH + 2;
  localparam int PW    = WIDTH + 3;
  localparam int CW    = $clog2(NSTEP);
  localparam logic [CW-1:0] LAST = CW'(NSTEP - 1);

  typedef enum logic [1:0] {IDLE, RUN, WAIT_ACK} state_t;

  state_t               r_state;
  logic                 r_startQ;
  logic [CW-1:0]        r_count;
  logic [EW-1:0]        r_a;
  logic [PW-1:0]        r_acc;
  logic [PW-1:0]        r_mul;
  logic                 r_busy;
  logic                 r_irq;
  logic                 r_done;
  logic [2*WIDTH-1:0]   r_result;
`ifdef BOOTH_MUL_ACC_EN
  logic                 r_accMode;
`endif

  logic                 w_edge;
  logic [EW-1:0]        w_aExt;
  logic [EW-1:0]        w_bExt;
  logic [PW-1:0]        w_aPart;
  logic [2:0]           w_window;
  logic [PW-1:0]        w_addend;
  logic [PW-1:0]        w_sum;
  logic [PW-1:0]        w_accNext;
  logic [PW-1:0]        w_mulNext;
  logic [2*WIDTH-1:0]   w_product;
  logic [2*WIDTH-1:0]   w_resultNext;

  assign w_edge = bus.i_start & ~r_startQ;
  assign w_aExt = bus.i_signedMode ? {{2{bus.i_dataA[WIDTH-1]}}, bus.i_dataA}
                                   : {2'b00, bus.i_dataA};
  assign w_bExt = bus.i_signedMode ? {{2{bus.i_dataB[WIDTH-1]}}, bus.i_dataB}
                                   : {2'b00, bus.i_dataB};

  // r_mul holds the unconsumed multiplier bits with b[-1] at bit 0; product bits shift in at the top
  assign w_aPart  = {r_a[EW-1], r_a};
  assign w_window = r_mul[2:0];

  always_comb begin
    w_addend = '0;
    case (w_window)
      3'b001, 3'b010: w_addend = w_aPart;
      3'b011:         w_addend = w_aPart << 1;
      3'b100:         w_addend = -(w_aPart << 1);
      3'b101, 3'b110: w_addend = -w_aPart;
      default:        w_addend = '0;
    endcase
  end

  assign w_sum     = r_acc + w_addend;
  assign w_accNext = {{2{w_sum[PW-1]}}, w_sum[PW-1:2]};
  assign w_mulNext = {w_sum[1:0], r_mul[PW-1:2]};
  // After the last step the low WIDTH+2 product bits sit in r_mul[PW-1:1]
  assign w_product = {w_accNext[WIDTH-3:0], w_mulNext[PW-1:1]};

`ifdef BOOTH_MUL_ACC_EN
  assign w_resultNext = r_accMode ? (r_result + w_product) : w_product;
`else
  assign w_resultNext = w_product;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_state  <= IDLE;
      r_startQ <= 1'b0;
      r_count  <= '0;
      r_a      <= '0;
      r_acc    <= '0;
      r_mul    <= '0;
      r_busy   <= 1'b0;
      r_irq    <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
`ifdef BOOTH_MUL_ACC_EN
      r_accMode <= 1'b0;
`endif
    end else begin
      r_startQ <= bus.i_start;
      r_done   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_edge) begin
            r_a     <= w_aExt;
            r_mul   <= {w_bExt, 1'b0};
            r_acc   <= '0;
            r_count <= '0;
            r_busy  <= 1'b1;
            r_state <= RUN;
`ifdef BOOTH_MUL_ACC_EN
            r_accMode <= bus.i_accEn;
`endif
          end
        end
        RUN: begin
          r_acc   <= w_accNext;
          r_mul   <= w_mulNext;
          r_count <= r_count + CW'(1);
          if (r_count == LAST) begin
            r_result <= w_resultNext;
            r_done   <= 1'b1;
            if (bus.i_irqEnable) begin
              r_irq   <= 1'b1;
              r_state <= WAIT_ACK;
            end else begin
              r_busy  <= 1'b0;
              r_state <= IDLE;
            end
          end
        end
        WAIT_ACK: begin
          if (bus.i_ack) begin
            r_irq   <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.o_busy   = r_busy;
  assign bus.o_irq    = r_irq;
  assign bus.o_done   = r_done;
  assign bus.o_result = r_result;
endmodule
